rat_intr_ctrl: RTL and testbench
================================

Name: rat_intr_ctrl

Overview:
Prioritised interrupt controller in front of the RAT CPU's single INTR input. It edge-detects up to four peripheral request lines and latches them as pending. It holds a software-programmed mask and presents one registered INTR request at a time until the ISR acknowledges it. Software accesses it through the existing OUT/IN port scheme (IO_STRB/PORT_ID/OUT_PORT for writes; IRQ_DATA is muxed into IN_PORT for reads).

Parameters:
NUM_SRC, 4, number of request sources (1..4)
MASK_PORT, 8'h20, port ID: write = set mask, read = mask readback
STAT_PORT, 8'h21, port ID: read-only status/ID
ACK_PORT, 8'h22, port ID: write = acknowledge active source (data ignored)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
SRC_IRQ  in  NUM_SRC  peripheral requests, synchronous to CLK, rising-edge significant
IO_STRB  in  1  CPU output strobe, one cycle per OUT instruction
PORT_ID  in  8  CPU port address
OUT_PORT  in  8  CPU output data
INTR  out  1  registered interrupt request to the CPU
IRQ_DATA  out  8  read data for the IN_PORT mux
IRQ_DATA_VLD  out  1  high when PORT_ID equals MASK_PORT or STAT_PORT

Behaviour:
- Reset (RESET_N low, async): state=IDLE, mask=0, pending=0, src_q=0, ACTIVE_ID=0, INTR=0. IRQ_DATA and IRQ_DATA_VLD are combinational from PORT_ID/state and reflect the reset registers.
- Edge detect: src_q<=SRC_IRQ each cycle. Rising edge = SRC_IRQ & ~src_q, which sets the pending bit on the next edge. A level held high sets the bit once only. Edges are detected whether or not the source is masked.
- Mask write: IO_STRB && PORT_ID==MASK_PORT -> mask<=OUT_PORT[NUM_SRC-1:0]. Upper bits are ignored.
- eligible = pending & mask. Priority: lowest index wins.
- FSM (registered; INTR is a registered output equal to state==REQ):
  - IDLE: if eligible!=0 -> REQ, and ACTIVE_ID <= lowest set index of eligible.
  - REQ: INTR=1, and ACTIVE_ID stays frozen even if a higher-priority source becomes pending.
    - ACK write (IO_STRB && PORT_ID==ACK_PORT) -> clear pending[ACTIVE_ID], go to GAP.
    - else if mask[ACTIVE_ID]==0 -> IDLE, pending is kept, INTR drops the following cycle.
  - GAP: INTR=0 for exactly one cycle, then IDLE. This guarantees a visible low between back-to-back requests.
- Latency: SRC_IRQ rises in cycle N (sampled at edge N) -> pending set at N+1 -> INTR=1 at N+2, when starting from IDLE with the source unmasked.
- ACK write when not in REQ: no effect. Mask write and ACK write in the same cycle cannot occur, since there is one port per strobe.
- Simultaneous new edge on ACTIVE_ID and ACK in the same cycle: the set wins, so pending stays 1 and a fresh REQ follows after GAP.
- Reads (combinational):
  - PORT_ID==STAT_PORT -> IRQ_DATA = {state==REQ, 1'b0, ACTIVE_ID[1:0], pending[3:0]}, with unused pending bits zero.
  - PORT_ID==MASK_PORT -> IRQ_DATA = {4'b0, mask}, zero-padded.
  - Otherwise IRQ_DATA=0 and IRQ_DATA_VLD=0.
- Reads never change state.
- Reset asserted mid-REQ: INTR drops immediately (async) and all pending requests are lost.

Test Plan:
1. Reset, mask=4'b0001, pulse SRC_IRQ[0] in cycle N -> INTR=1 at N+2. STAT read = 8'h81. ACK write -> INTR=0 next cycle. STAT = 8'h00.
2. mask=4'b1111, SRC_IRQ[3] and [1] rise together -> ACTIVE_ID=1 and STAT=8'h9A. After ACK: one cycle with INTR low (GAP), then INTR=1 with STAT=8'hB8. After second ACK, pending=0.
3. mask=0, pulse SRC_IRQ[2] -> INTR stays 0 and STAT=8'h04. Write mask=8'h04 -> INTR=1 two cycles later.
4. In REQ for source 0, write mask=0 -> INTR=0 the following cycle, pending[0] still 1. Rewrite mask=1 -> INTR reasserts.
5. Hold SRC_IRQ[0] high for 10 cycles -> only one pending set. A new edge of SRC_IRQ[0] coincident with ACK -> pending[0]=1 after GAP and INTR reasserts.
6. Drop RESET_N while INTR=1 -> INTR=0 without waiting for a clock edge. After release: mask=0, pending=0, and IRQ_DATA_VLD=1 only at ports 8'h20 and 8'h21.

Source files
------------

// File: rtl/rat_intr_ctrl_if.sv
// Bus bundle between the RAT CPU port scheme, the peripheral request lines
// and the interrupt controller.
interface rat_intr_ctrl_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] SRC_IRQ;
    logic               IO_STRB;
    logic [7:0]         PORT_ID;
    logic [7:0]         OUT_PORT;
    logic               INTR;
    logic [7:0]         IRQ_DATA;
    logic               IRQ_DATA_VLD;

    modport master (
        output SRC_IRQ, IO_STRB, PORT_ID, OUT_PORT,
        input  INTR, IRQ_DATA, IRQ_DATA_VLD
    );

    modport slave (
        input  SRC_IRQ, IO_STRB, PORT_ID, OUT_PORT,
        output INTR, IRQ_DATA, IRQ_DATA_VLD
    );
endinterface

// File: rtl/rat_intr_ctrl.sv
// Prioritised interrupt controller for the RAT CPU: edge-detects up to four
// request lines, masks them, and presents one acknowledged request at a time.
module rat_intr_ctrl #(
    parameter int          NUM_SRC   = 4,
    parameter logic [7:0]  MASK_PORT = 8'h20,
    parameter logic [7:0]  STAT_PORT = 8'h21,
    parameter logic [7:0]  ACK_PORT  = 8'h22
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    rat_intr_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] src_q, pending, mask;
    logic [NUM_SRC-1:0] rise, eligible, pend_clr;
    logic [1:0]         active_id, active_id_nxt, first_id;
    logic [3:0]         pend4, mask4;
    logic               mask_wr, ack_wr;
    logic               unused_out_bits;

    assign mask_wr  = bus.IO_STRB && (bus.PORT_ID == MASK_PORT);
    assign ack_wr   = bus.IO_STRB && (bus.PORT_ID == ACK_PORT);
    assign rise     = bus.SRC_IRQ & ~src_q;
    assign eligible = pending & mask;

    // Only the low NUM_SRC data bits carry mask information.
    assign unused_out_bits = ^bus.OUT_PORT[7:NUM_SRC];

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        first_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) first_id = 2'(i);
        end
    end

    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    always_comb begin
        state_nxt     = state;
        active_id_nxt = active_id;
        pend_clr      = '0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt     = REQ;
                    active_id_nxt = first_id;
                end
            end
            REQ: begin
                if (ack_wr) begin
                    pend_clr[active_id] = 1'b1;
                    state_nxt           = GAP;
                end else if (!mask[active_id]) begin
                    state_nxt = IDLE;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            active_id <= '0;
            src_q     <= '0;
            mask      <= '0;
            pending   <= '0;
        end else begin
            state     <= state_nxt;
            active_id <= active_id_nxt;
            src_q     <= bus.SRC_IRQ;
            if (mask_wr) mask <= bus.OUT_PORT[NUM_SRC-1:0];
            // A fresh edge on the acknowledged source beats the clear.
            pending   <= (pending & ~pend_clr) | rise;
        end
    end

    // Decoded straight from the state register, so reset drops it at once.
    assign bus.INTR = (state == REQ);

    always_comb begin
        pend4                 = '0;
        mask4                 = '0;
        pend4[NUM_SRC-1:0]    = pending;
        mask4[NUM_SRC-1:0]    = mask;
        bus.IRQ_DATA          = '0;
        bus.IRQ_DATA_VLD      = 1'b0;
        if (bus.PORT_ID == STAT_PORT) begin
            bus.IRQ_DATA     = {state == REQ, 1'b0, active_id, pend4};
            bus.IRQ_DATA_VLD = 1'b1;
        end else if (bus.PORT_ID == MASK_PORT) begin
            bus.IRQ_DATA     = {4'b0000, mask4};
            bus.IRQ_DATA_VLD = 1'b1;
        end
    end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed self-checking bench for rat_intr_ctrl; expected values are
// hand-computed from the controller's documented behaviour.
module tb_rat_intr_ctrl;

    localparam logic [7:0] MASK_PORT = 8'h20;
    localparam logic [7:0] STAT_PORT = 8'h21;
    localparam logic [7:0] ACK_PORT  = 8'h22;

    logic CLK;
    logic RESET_N;
    int   chk_cnt;
    int   pass_cnt;

    rat_intr_ctrl_if #(.NUM_SRC(4)) bus_if ();

    rat_intr_ctrl #(
        .NUM_SRC   (4),
        .MASK_PORT (MASK_PORT),
        .STAT_PORT (STAT_PORT),
        .ACK_PORT  (ACK_PORT)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        bus_if.IO_STRB  = 1'b1;
        bus_if.PORT_ID  = port;
        bus_if.OUT_PORT = data;
        tick();
        bus_if.IO_STRB  = 1'b0;
        bus_if.PORT_ID  = 8'h00;
        bus_if.OUT_PORT = 8'h00;
    endtask

    task automatic io_read(input logic [7:0] port, output logic [7:0] data,
                           output logic vld);
        bus_if.PORT_ID = port;
        #1;
        data = bus_if.IRQ_DATA;
        vld  = bus_if.IRQ_DATA_VLD;
        bus_if.PORT_ID = 8'h00;
        #1;
    endtask

    task automatic do_reset();
        bus_if.SRC_IRQ  = '0;
        bus_if.IO_STRB  = 1'b0;
        bus_if.PORT_ID  = 8'h00;
        bus_if.OUT_PORT = 8'h00;
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v;
        do_reset();
        chk_cnt++;
        if (bus_if.INTR !== 1'b0) $display("FAIL reset_intr got %b exp 0", bus_if.INTR);
        else pass_cnt++;
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h00 || v !== 1'b1) $display("FAIL reset_stat got %h/%b exp 00/1", d, v);
        else pass_cnt++;
        io_read(MASK_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h00 || v !== 1'b1) $display("FAIL reset_mask got %h/%b exp 00/1", d, v);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       v;
        do_reset();
        io_write(MASK_PORT, 8'h01);
        bus_if.SRC_IRQ = 4'b0001;
        tick();
        bus_if.SRC_IRQ = 4'b0000;
        chk_cnt++;
        if (bus_if.INTR !== 1'b0) $display("FAIL basic_lat1 got %b exp 0", bus_if.INTR);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus_if.INTR !== 1'b1) $display("FAIL basic_lat2 got %b exp 1", bus_if.INTR);
        else pass_cnt++;
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h81) $display("FAIL basic_stat_req got %h exp 81", d);
        else pass_cnt++;
        io_write(ACK_PORT, 8'hFF);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0) $display("FAIL basic_ack_intr got %b exp 0", bus_if.INTR);
        else pass_cnt++;
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h00) $display("FAIL basic_stat_ack got %h exp 00", d);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        logic [7:0] d;
        logic       v;
        do_reset();
        io_write(MASK_PORT, 8'h0F);
        bus_if.SRC_IRQ = 4'b1010;
        tick();
        bus_if.SRC_IRQ = 4'b0000;
        tick();
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b1 || d !== 8'h9A)
            $display("FAIL prio_first got intr=%b stat=%h exp 1/9a", bus_if.INTR, d);
        else pass_cnt++;
        io_write(ACK_PORT, 8'h00);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0) $display("FAIL prio_gap got %b exp 0", bus_if.INTR);
        else pass_cnt++;
        tick();
        tick();
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b1 || d !== 8'hB8)
            $display("FAIL prio_second got intr=%b stat=%h exp 1/b8", bus_if.INTR, d);
        else pass_cnt++;
        io_write(ACK_PORT, 8'h00);
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h30) $display("FAIL prio_drained got %h exp 30", d);
        else pass_cnt++;
    endtask

    task automatic test_mask_gate();
        logic [7:0] d;
        logic       v;
        do_reset();
        bus_if.SRC_IRQ = 4'b0100;
        tick();
        bus_if.SRC_IRQ = 4'b0000;
        tick();
        tick();
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0 || d !== 8'h04)
            $display("FAIL masked_pend got intr=%b stat=%h exp 0/04", bus_if.INTR, d);
        else pass_cnt++;
        io_write(MASK_PORT, 8'hF4);
        io_read(MASK_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0 || d !== 8'h04 || v !== 1'b1)
            $display("FAIL mask_rb got intr=%b mask=%h vld=%b exp 0/04/1", bus_if.INTR, d, v);
        else pass_cnt++;
        tick();
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b1 || d !== 8'hA4)
            $display("FAIL unmask_req got intr=%b stat=%h exp 1/a4", bus_if.INTR, d);
        else pass_cnt++;
    endtask

    task automatic test_mask_drop();
        logic [7:0] d;
        logic       v;
        do_reset();
        io_write(MASK_PORT, 8'h01);
        bus_if.SRC_IRQ = 4'b0001;
        tick();
        bus_if.SRC_IRQ = 4'b0000;
        tick();
        io_write(MASK_PORT, 8'h00);
        tick();
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0 || d !== 8'h01)
            $display("FAIL drop_req got intr=%b stat=%h exp 0/01", bus_if.INTR, d);
        else pass_cnt++;
        io_write(MASK_PORT, 8'h01);
        tick();
        chk_cnt++;
        if (bus_if.INTR !== 1'b1) $display("FAIL drop_reassert got %b exp 1", bus_if.INTR);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       v;
        do_reset();
        io_write(MASK_PORT, 8'h01);
        bus_if.SRC_IRQ = 4'b0001;
        tick();
        tick();
        io_write(ACK_PORT, 8'h00);
        for (int i = 0; i < 7; i++) tick();
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0 || d !== 8'h00)
            $display("FAIL level_once got intr=%b stat=%h exp 0/00", bus_if.INTR, d);
        else pass_cnt++;
        bus_if.SRC_IRQ = 4'b0000;
        tick();
        bus_if.SRC_IRQ = 4'b0001;
        tick();
        bus_if.SRC_IRQ = 4'b0000;
        tick();
        bus_if.SRC_IRQ = 4'b0001;
        io_write(ACK_PORT, 8'h00);
        bus_if.SRC_IRQ = 4'b0000;
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (bus_if.INTR !== 1'b0 || d !== 8'h01)
            $display("FAIL set_wins got intr=%b stat=%h exp 0/01", bus_if.INTR, d);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (bus_if.INTR !== 1'b1) $display("FAIL set_wins_req got %b exp 1", bus_if.INTR);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        logic       v;
        logic [7:0] ports   [5];
        logic       exp_vld [5];
        ports   = '{8'h20, 8'h21, 8'h22, 8'h00, 8'hFF};
        exp_vld = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        io_write(MASK_PORT, 8'h01);
        bus_if.SRC_IRQ = 4'b0001;
        tick();
        bus_if.SRC_IRQ = 4'b0000;
        tick();
        #2;
        RESET_N = 1'b0;
        #1;
        chk_cnt++;
        if (bus_if.INTR !== 1'b0) $display("FAIL async_drop got %b exp 0", bus_if.INTR);
        else pass_cnt++;
        tick();
        RESET_N = 1'b1;
        tick();
        io_read(MASK_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h00) $display("FAIL rst_mask got %h exp 00", d);
        else pass_cnt++;
        io_read(STAT_PORT, d, v);
        chk_cnt++;
        if (d !== 8'h00) $display("FAIL rst_pend got %h exp 00", d);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            io_read(ports[i], d, v);
            chk_cnt++;
            if (v !== exp_vld[i] || (!exp_vld[i] && d !== 8'h00))
                $display("FAIL vld_port_%h got vld=%b data=%h exp vld=%b", ports[i], v, d, exp_vld[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        RESET_N  = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask_gate();
        test_mask_drop();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
